flit_reassembly_buffer: RTL and testbench

Parametrised successor to the single-configuration flit merge buffer, sitting between the NoC router port and the bridge master. Per source node, it reassembles PAYLOAD_W-wide flits into REQ_W-wide requests. Completed requests are queued in arrival order and handed to the bridge. Each bridge response is split into flits and returned to the originating node, with put backpressure, tail marking and malformed-packet detection.

---
 rtl/flit_buf_pkg.sv | 41 ++++
 rtl/flit_id_fifo.sv | 49 ++++
 rtl/flit_reassembly_buffer.sv | 249 ++++++++++++++++++++++++
 tb/tb_flit_reassembly_buffer.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flit_buf_pkg.sv
// Shared constants, flit field offsets and FSM state type for the flit reassembly buffer.
package flit_buf_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StSend} state_e;

  function automatic int unsigned node_width(input int unsigned num_nodes);
    return (num_nodes > 1) ? $clog2(num_nodes) : 1;
  endfunction

  function automatic int unsigned num_flits(input int unsigned req_w, input int unsigned payload_w);
    return (req_w + payload_w - 1) / payload_w;
  endfunction

  function automatic int unsigned last_width(input int unsigned req_w,
                                             input int unsigned payload_w);
    return req_w - (num_flits(req_w, payload_w) - 1) * payload_w;
  endfunction

  // Flit layout, LSB upwards: payload, src, zero bit, dst, tail, valid.
  function automatic int unsigned src_lsb(input int unsigned payload_w);
    return payload_w;
  endfunction

  function automatic int unsigned zero_bit(input int unsigned payload_w, input int unsigned node_w);
    return payload_w + node_w;
  endfunction

  function automatic int unsigned dst_lsb(input int unsigned payload_w, input int unsigned node_w);
    return payload_w + node_w + 1;
  endfunction

  function automatic int unsigned tail_bit(input int unsigned payload_w, input int unsigned node_w);
    return payload_w + 2 * node_w + 1;
  endfunction

  function automatic int unsigned valid_bit(input int unsigned payload_w,
                                            input int unsigned node_w);
    return payload_w + 2 * node_w + 2;
  endfunction

endpackage

// File: rtl/flit_id_fifo.sv
// Synchronous FIFO holding ids of nodes whose request is complete, in completion order.
module flit_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push != do_pop) count_q <= do_push ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/flit_reassembly_buffer.sv
// Reassembles per-node NoC flits into bridge requests and splits responses back into flits.
// Optional partial-request timeout is enabled with `define FLIT_BUF_TIMEOUT_EN.
module flit_reassembly_buffer
  import flit_buf_pkg::*;
#(
  parameter int unsigned NUM_NODES = 4,
  parameter int unsigned PAYLOAD_W = 32,
  parameter int unsigned REQ_W     = 72,
`ifdef FLIT_BUF_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 1024,
`endif
  localparam int unsigned NODE_W = node_width(NUM_NODES),
  localparam int unsigned NFLITS = num_flits(REQ_W, PAYLOAD_W),
  localparam int unsigned LAST_W = last_width(REQ_W, PAYLOAD_W),
  localparam int unsigned FLIT_W = PAYLOAD_W + 2 * NODE_W + 3
) (
  input  logic              clk,
  input  logic              res,
  input  logic [FLIT_W-1:0] noc_get_flit,
  output logic              noc_get_en,
  output logic [FLIT_W-1:0] noc_put_flit,
  output logic              noc_put_en,
  input  logic              noc_put_ready,
  input  logic [NODE_W-1:0] this_id,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [REQ_W-1:0]  req_data,
  input  logic              rsp_valid,
  output logic              rsp_ready,
  input  logic [REQ_W-1:0]  rsp_data,
`ifdef FLIT_BUF_TIMEOUT_EN
  output logic              err_timeout,
`endif
  output logic              err_overrun,
  output logic              err_malformed
);
  localparam int unsigned IDX_W     = (NFLITS > 1) ? $clog2(NFLITS) : 1;
  localparam int unsigned PAD_W     = NFLITS * PAYLOAD_W;
  localparam int unsigned SRC_LSB   = src_lsb(PAYLOAD_W);
  localparam int unsigned ZERO_BIT  = zero_bit(PAYLOAD_W, NODE_W);
  localparam int unsigned DST_LSB   = dst_lsb(PAYLOAD_W, NODE_W);
  localparam int unsigned TAIL_BIT  = tail_bit(PAYLOAD_W, NODE_W);
  localparam int unsigned VALID_BIT = valid_bit(PAYLOAD_W, NODE_W);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q [NUM_NODES];
  logic [IDX_W-1:0]     idx_d [NUM_NODES];
  logic [NUM_NODES-1:0] lock_q, lock_d;
  logic [PAYLOAD_W-1:0] slot_q [NUM_NODES][NFLITS];
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic [NODE_W-1:0]    cur_id_q, fifo_head;
  logic [REQ_W-1:0]     req_q, req_asm, rsp_q;
  logic [PAD_W-1:0]     rsp_pad;
  logic [PAYLOAD_W-1:0] chunk;
  logic                 overrun_q, malformed_q, set_overrun, set_malformed;
  logic                 push, pop, fifo_empty, fifo_full;
  logic                 slot_we, accept, release_lock, latch_rsp, send_last;
  logic                 in_valid, in_tail, in_last, src_ok;
  logic [NODE_W-1:0]    in_src;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 unused_bits;

  assign in_valid    = noc_get_flit[VALID_BIT];
  assign in_tail     = noc_get_flit[TAIL_BIT];
  assign in_src      = noc_get_flit[SRC_LSB +: NODE_W];
  assign in_payload  = noc_get_flit[PAYLOAD_W-1:0];
  assign unused_bits = ^{noc_get_flit[DST_LSB +: NODE_W], noc_get_flit[ZERO_BIT], fifo_full};
  assign in_last     = (idx_q[in_src] == IDX_W'(NFLITS - 1));

  if (2 ** NODE_W == NUM_NODES) begin : g_full_range
    assign src_ok = 1'b1;
  end else begin : g_part_range
    assign src_ok = (32'(in_src) < NUM_NODES);
  end

  assign noc_get_en    = ~res;
  assign req_data      = req_q;
  assign err_overrun   = overrun_q;
  assign err_malformed = malformed_q;

`ifdef FLIT_BUF_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q [NUM_NODES];
  logic [TMO_W-1:0] tmo_d [NUM_NODES];
  logic             timeout_q, set_timeout;
  assign err_timeout = timeout_q;
`endif

  // Ingress: the lock release of the node being served wins over a same-cycle flit check.
  always_comb begin
    idx_d         = idx_q;
    lock_d        = lock_q;
    slot_we       = 1'b0;
    accept        = 1'b0;
    push          = 1'b0;
    set_overrun   = 1'b0;
    set_malformed = 1'b0;
    if (release_lock) lock_d[cur_id_q] = 1'b0;
    if (in_valid && src_ok) begin
      if (lock_d[in_src]) begin
        set_overrun = 1'b1;
      end else begin
        accept = 1'b1;
        if (in_tail != in_last) begin
          set_malformed = 1'b1;
          idx_d[in_src] = '0;
        end else begin
          slot_we = 1'b1;
          if (in_last) begin
            lock_d[in_src] = 1'b1;
            push           = 1'b1;
            idx_d[in_src]  = '0;
          end else begin
            idx_d[in_src] = idx_q[in_src] + 1'b1;
          end
        end
      end
    end
`ifdef FLIT_BUF_TIMEOUT_EN
    set_timeout = 1'b0;
    for (int n = 0; n < NUM_NODES; n++) begin
      tmo_d[n] = '0;
      if (!(accept && in_src == NODE_W'(n)) && idx_q[n] != '0 && !lock_q[n]) begin
        if (tmo_q[n] == TMO_W'(TIMEOUT_CYC - 1)) begin
          idx_d[n]    = '0;
          set_timeout = 1'b1;
        end else begin
          tmo_d[n] = tmo_q[n] + 1'b1;
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (slot_we) slot_q[in_src][idx_q[in_src]] <= in_payload;
  end

  // Lower flits fill whole payload words; only LAST_W bits of the final flit are kept.
  always_comb begin
    req_asm = '0;
    for (int i = 0; i < NFLITS - 1; i++) begin
      req_asm[i*PAYLOAD_W +: PAYLOAD_W] = slot_q[fifo_head][i];
    end
    req_asm[REQ_W-1 -: LAST_W] = slot_q[fifo_head][NFLITS-1][LAST_W-1:0];
  end

  assign rsp_pad   = PAD_W'(rsp_q);
  assign chunk     = rsp_pad[32'(cnt_q) * PAYLOAD_W +: PAYLOAD_W];
  assign send_last = (cnt_q == IDX_W'(NFLITS - 1));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    latch_rsp    = 1'b0;
    release_lock = 1'b0;
    req_valid    = 1'b0;
    rsp_ready    = 1'b0;
    noc_put_en   = 1'b0;
    noc_put_flit = '0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = StReq;
        end
      end
      StReq: begin
        req_valid = 1'b1;
        if (req_ready) state_d = StWaitRsp;
      end
      StWaitRsp: begin
        rsp_ready = 1'b1;
        if (rsp_valid) begin
          latch_rsp = 1'b1;
          cnt_d     = '0;
          state_d   = StSend;
        end
      end
      StSend: begin
        noc_put_en   = 1'b1;
        noc_put_flit = {1'b1, send_last, cur_id_q, 1'b0, this_id, chunk};
        if (noc_put_ready) begin
          if (send_last) begin
            release_lock = 1'b1;
            state_d      = StIdle;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= StIdle;
      lock_q      <= '0;
      cnt_q       <= '0;
      cur_id_q    <= '0;
      req_q       <= '0;
      rsp_q       <= '0;
      overrun_q   <= 1'b0;
      malformed_q <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++) idx_q[n] <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      for (int n = 0; n < NUM_NODES; n++) idx_q[n] <= idx_d[n];
      if (pop) begin
        cur_id_q <= fifo_head;
        req_q    <= req_asm;
      end
      if (latch_rsp)     rsp_q       <= rsp_data;
      if (set_overrun)   overrun_q   <= 1'b1;
      if (set_malformed) malformed_q <= 1'b1;
    end
  end

`ifdef FLIT_BUF_TIMEOUT_EN
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      timeout_q <= 1'b0;
      for (int n = 0; n < NUM_NODES; n++) tmo_q[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_NODES; n++) tmo_q[n] <= tmo_d[n];
      if (set_timeout) timeout_q <= 1'b1;
    end
  end
`endif

  flit_id_fifo #(
    .DEPTH (NUM_NODES),
    .WIDTH (NODE_W)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (res),
    .push      (push),
    .push_data (in_src),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_flit_reassembly_buffer.sv
// Directed self-checking bench for flit_reassembly_buffer with default parameters.
module tb_flit_reassembly_buffer;
  localparam int FW = 39;
  localparam logic [1:0] THIS_ID = 2'd1;

  logic          clk = 1'b0;
  logic          res;
  logic [FW-1:0] noc_get_flit, noc_put_flit;
  logic          noc_get_en, noc_put_en, noc_put_ready;
  logic [1:0]    this_id;
  logic          req_valid, req_ready, rsp_valid, rsp_ready;
  logic [71:0]   req_data, rsp_data;
  logic          err_overrun, err_malformed;
`ifdef FLIT_BUF_TIMEOUT_EN
  logic          err_timeout;
`endif
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  flit_reassembly_buffer dut (
    .clk           (clk),
    .res           (res),
    .noc_get_flit  (noc_get_flit),
    .noc_get_en    (noc_get_en),
    .noc_put_flit  (noc_put_flit),
    .noc_put_en    (noc_put_en),
    .noc_put_ready (noc_put_ready),
    .this_id       (this_id),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_data      (req_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
`ifdef FLIT_BUF_TIMEOUT_EN
    .err_timeout   (err_timeout),
`endif
    .err_overrun   (err_overrun),
    .err_malformed (err_malformed)
  );

  function automatic logic [FW-1:0] in_flit(input logic tail, input logic [1:0] src,
                                            input logic [31:0] p);
    return {1'b1, tail, 2'b00, 1'b0, src, p};
  endfunction

  function automatic logic [FW-1:0] out_flit(input logic [1:0] dst, input int k,
                                             input logic [71:0] r);
    logic [31:0] p;
    logic        tail;
    if (k == 0)      p = r[31:0];
    else if (k == 1) p = r[63:32];
    else             p = {24'h0, r[71:64]};
    tail = (k == 2);
    return {1'b1, tail, dst, 1'b0, THIS_ID, p};
  endfunction

  task automatic send(input logic [FW-1:0] f);
    noc_get_flit = f;
    @(negedge clk);
    noc_get_flit = '0;
  endtask

  task automatic send_pkt(input logic [1:0] src, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c);
    send(in_flit(1'b0, src, a));
    send(in_flit(1'b0, src, b));
    send(in_flit(1'b1, src, c));
  endtask

  task automatic wait_req(output bit ok, output logic [71:0] data);
    ok = 1'b0;
    data = '0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_valid) begin
        ok = 1'b1;
        data = req_data;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic accept_req();
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic [71:0] r, output bit took);
    took = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = r;
    for (int i = 0; i < 20; i++) begin
      if (rsp_ready) begin
        took = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  task automatic collect(output logic [2:0][FW-1:0] fl, output int n);
    n = 0;
    fl = '0;
    noc_put_ready = 1'b1;
    for (int i = 0; i < 30 && n < 3; i++) begin
      if (noc_put_en) begin
        fl[n] = noc_put_flit;
        n++;
      end
      @(negedge clk);
    end
    noc_put_ready = 1'b0;
  endtask

  // Full request/response round trip with a checked request and returned flit stream.
  task automatic round_trip(input string tag, input logic [1:0] node, input logic [71:0] exp_req,
                            input logic [71:0] r);
    bit                  ok;
    logic [71:0]         d;
    logic [2:0][FW-1:0]  fl;
    int                  n;
    wait_req(ok, d);
    n_cmp++;
    if (!ok || d !== exp_req) begin
      n_err++;
      $display("FAIL %s_req: ok=%0b data=%h want %h", tag, ok, d, exp_req);
    end
    accept_req();
    respond(r, ok);
    collect(fl, n);
    n_cmp++;
    if (n !== 3) begin
      n_err++;
      $display("FAIL %s_nflits: got %0d want 3", tag, n);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (fl[k] !== out_flit(node, k, r)) begin
        n_err++;
        $display("FAIL %s_flit%0d: got %h want %h", tag, k, fl[k], out_flit(node, k, r));
      end
    end
    n_cmp++;
    if (noc_put_en !== 1'b0) begin
      n_err++;
      $display("FAIL %s_put_done: noc_put_en=%b want 0", tag, noc_put_en);
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({req_valid, rsp_ready, noc_put_en, noc_get_en} !== 4'b0) begin
      n_err++;
      $display("FAIL rst_ctrl: %b want 0000", {req_valid, rsp_ready, noc_put_en, noc_get_en});
    end
    n_cmp++;
    if (noc_put_flit !== '0 || req_data !== '0) begin
      n_err++;
      $display("FAIL rst_data: put=%h req=%h want 0", noc_put_flit, req_data);
    end
    n_cmp++;
    if ({err_overrun, err_malformed} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_err: %b want 00", {err_overrun, err_malformed});
    end
    res = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (noc_get_en !== 1'b1 || req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release: get_en=%b req_valid=%b want 1 0", noc_get_en, req_valid);
    end
  endtask

  task automatic test_basic();
    logic [71:0]         r;
    logic [2:0][FW-1:0]  fl;
    int                  n;
    bit                  took;
    r = 72'h5A_DEADBEEF_01234567;
    send_pkt(2'd2, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3);
    n_cmp++;
    if (req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_lat_t1: req_valid=%b want 0", req_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (req_valid !== 1'b1 || req_data !== 72'hC3_B0B1B2B3_A0A1A2A3) begin
      n_err++;
      $display("FAIL basic_lat_t2: valid=%b data=%h want 1 %h", req_valid, req_data,
               72'hC3_B0B1B2B3_A0A1A2A3);
    end
    accept_req();
    n_cmp++;
    if (rsp_ready !== 1'b1 || req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_wait: rsp_ready=%b req_valid=%b want 1 0", rsp_ready, req_valid);
    end
    respond(r, took);
    collect(fl, n);
    n_cmp++;
    if (n !== 3) begin
      n_err++;
      $display("FAIL basic_nflits: got %0d want 3", n);
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (fl[k] !== out_flit(2'd2, k, r)) begin
        n_err++;
        $display("FAIL basic_flit%0d: got %h want %h", k, fl[k], out_flit(2'd2, k, r));
      end
    end
  endtask

  task automatic test_interleave();
    send(in_flit(1'b0, 2'd0, 32'h00000010));
    send(in_flit(1'b0, 2'd3, 32'h33330000));
    send(in_flit(1'b0, 2'd3, 32'h33331111));
    send(in_flit(1'b0, 2'd0, 32'h00000011));
    send(in_flit(1'b1, 2'd3, 32'h333322EE));
    send(in_flit(1'b1, 2'd0, 32'h000000DD));
    round_trip("ilv_n3", 2'd3, 72'hEE_33331111_33330000, 72'h31_CAFE0003_F00D0003);
    round_trip("ilv_n0", 2'd0, 72'hDD_00000011_00000010, 72'h07_CAFE0000_F00D0000);
  endtask

  task automatic test_backpressure();
    bit          ok;
    logic [71:0] d, r;
    r = 72'h9C_87654321_0F1E2D3C;
    send_pkt(2'd1, 32'h11110000, 32'h11110001, 32'h111100AB);
    wait_req(ok, d);
    n_cmp++;
    if (!ok || d !== 72'hAB_11110001_11110000) begin
      n_err++;
      $display("FAIL bp_req: ok=%0b data=%h", ok, d);
    end
    accept_req();
    respond(r, ok);
    noc_put_ready = 1'b1;
    n_cmp++;
    if (noc_put_en !== 1'b1 || noc_put_flit !== out_flit(2'd1, 0, r)) begin
      n_err++;
      $display("FAIL bp_flit0: en=%b got %h want %h", noc_put_en, noc_put_flit, out_flit(2'd1, 0, r));
    end
    @(negedge clk);
    noc_put_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (noc_put_en !== 1'b1 || noc_put_flit !== out_flit(2'd1, 1, r)) begin
        n_err++;
        $display("FAIL bp_hold%0d: en=%b got %h want %h", i, noc_put_en, noc_put_flit,
                 out_flit(2'd1, 1, r));
      end
      @(negedge clk);
    end
    noc_put_ready = 1'b1;
    n_cmp++;
    if (noc_put_flit !== out_flit(2'd1, 1, r)) begin
      n_err++;
      $display("FAIL bp_flit1: got %h want %h", noc_put_flit, out_flit(2'd1, 1, r));
    end
    @(negedge clk);
    n_cmp++;
    if (noc_put_en !== 1'b1 || noc_put_flit !== out_flit(2'd1, 2, r)) begin
      n_err++;
      $display("FAIL bp_flit2: en=%b got %h want %h", noc_put_en, noc_put_flit, out_flit(2'd1, 2, r));
    end
    @(negedge clk);
    noc_put_ready = 1'b0;
    n_cmp++;
    if (noc_put_en !== 1'b0) begin
      n_err++;
      $display("FAIL bp_once: noc_put_en=%b want 0", noc_put_en);
    end
  endtask

  task automatic test_overrun();
    n_cmp++;
    if (err_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_pre: err_overrun=%b want 0", err_overrun);
    end
    send_pkt(2'd1, 32'h12340000, 32'h12340001, 32'h123400E1);
    send_pkt(2'd1, 32'hBAD00000, 32'hBAD00001, 32'hBAD000FF);
    n_cmp++;
    if (err_overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_flag: err_overrun=%b want 1", err_overrun);
    end
    round_trip("ovr", 2'd1, 72'hE1_12340001_12340000, 72'h4D_00C0FFEE_76543210);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_dropped: req_valid=%b want 0", req_valid);
    end
  endtask

  task automatic test_malformed();
    n_cmp++;
    if (err_malformed !== 1'b0) begin
      n_err++;
      $display("FAIL mal_pre: err_malformed=%b want 0", err_malformed);
    end
    send(in_flit(1'b0, 2'd0, 32'hDEAD0000));
    send(in_flit(1'b1, 2'd0, 32'hDEAD0001));
    n_cmp++;
    if (err_malformed !== 1'b1) begin
      n_err++;
      $display("FAIL mal_flag: err_malformed=%b want 1", err_malformed);
    end
    send(in_flit(1'b0, 2'd0, 32'hDEAD0002));
    send(in_flit(1'b0, 2'd0, 32'hDEAD0003));
    send(in_flit(1'b0, 2'd0, 32'hDEAD0004));
    repeat (4) @(negedge clk);
    n_cmp++;
    if (req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mal_noreq: req_valid=%b want 0", req_valid);
    end
    send_pkt(2'd0, 32'h0000AAAA, 32'h0000BBBB, 32'h000000CC);
    round_trip("mal_good", 2'd0, 72'hCC_0000BBBB_0000AAAA, 72'h12_34567890_ABCDEF01);
  endtask

  task automatic test_reset_mid();
    bit          ok;
    logic [71:0] d;
    send_pkt(2'd2, 32'h22220000, 32'h22220001, 32'h22220002);
    wait_req(ok, d);
    accept_req();
    n_cmp++;
    if (rsp_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_wait: rsp_ready=%b want 1", rsp_ready);
    end
    send_pkt(2'd0, 32'h0F0F0000, 32'h0F0F0001, 32'h0F0F0002);
    #2;
    res = 1'b1;
    #1;
    n_cmp++;
    if ({req_valid, rsp_ready, noc_put_en, noc_get_en} !== 4'b0) begin
      n_err++;
      $display("FAIL rmid_ctrl: %b want 0000", {req_valid, rsp_ready, noc_put_en, noc_get_en});
    end
    n_cmp++;
    if (req_data !== '0 || noc_put_flit !== '0 || {err_overrun, err_malformed} !== 2'b00) begin
      n_err++;
      $display("FAIL rmid_data: req=%h put=%h err=%b want 0", req_data, noc_put_flit,
               {err_overrun, err_malformed});
    end
    @(negedge clk);
    res = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_fifo_empty: req_valid=%b want 0", req_valid);
    end
    send_pkt(2'd0, 32'h5555AAAA, 32'h6666BBBB, 32'h77777777);
    round_trip("rmid_fresh", 2'd0, 72'h77_6666BBBB_5555AAAA, 72'hF0_0A0B0C0D_01020304);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    res = 1'b1;
    noc_get_flit = '0;
    noc_put_ready = 1'b0;
    this_id = THIS_ID;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = '0;
    test_reset();
    test_basic();
    test_interleave();
    test_backpressure();
    test_overrun();
    test_malformed();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
